// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the two-requester APB master used by the GPIO bridge.
package apb_gpio_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, on contention the requester
// not served last wins. The history only moves when the grant is actually taken.
module apb_rr_arb2
  import apb_gpio_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // Index of the requester served last; reset to r1 so r0 is preferred first.
  logic last_q;

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance_i && (|gnt_o)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/apb_gpio_arb_master.sv
// APB master shared by two requesters: round-robin pick in IDLE, one SETUP/ACCESS transfer at
// a time, and a watchdog that aborts with err_o when PREADY never arrives.
module apb_gpio_arb_master
  import apb_gpio_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      we_i,
  input  logic [2*ADDR_W-1:0]     addr_i,
  input  logic [2*DATA_W-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [NUM_REQ-1:0]      err_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic                    PREADY,
  input  logic [DATA_W-1:0]       PRDATA
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] gnt_q, done_q, err_q;
  logic [DATA_W-1:0]  rdata_q, pwdata_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic               psel_q, penable_q, pwrite_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic               start, sel, timed_out;

  // The done_o cycle is always spent idle, which enforces the gap between transfers.
  assign start     = (state_q == IDLE) && !(|done_q) && (|req_i);
  assign sel       = arb_gnt[1];
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  apb_rr_arb2 u_arb (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .req_i    (req_i),
    .advance_i(start),
    .gnt_o    (arb_gnt)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q  <= SETUP;
            gnt_q    <= arb_gnt;
            psel_q   <= 1'b1;
            pwrite_q <= we_i[sel];
            paddr_q  <= sel ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
            pwdata_q <= sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // PREADY is checked first so a ready on the last allowed cycle still completes.
          if (PREADY || timed_out) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt_q     <= '0;
            done_q    <= gnt_q;
            cnt_q     <= '0;
            if (PREADY) begin
              if (!pwrite_q) rdata_q <= PRDATA;
            end else begin
              err_q <= gnt_q;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_gpio_arb_master.sv
// Bench for apb_gpio_arb_master: acts as both requesters and the APB slave, predicting each
// transfer from a transaction-level model (winner, wait cycles, outcome, read data).
module tb_apb_gpio_arb_master;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req, we;
  logic [63:0]       addr, wdata;
  logic [1:0]        gnt, done, err;
  logic [31:0]       rdata, paddr, pwdata, prdata;
  logic              psel, penable, pwrite, pready;

  always #5 clk = ~clk;

  apb_gpio_arb_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .gnt_o  (gnt),
    .done_o (done),
    .err_o  (err),
    .rdata_o(rdata),
    .PSEL   (psel),
    .PENABLE(penable),
    .PWRITE (pwrite),
    .PADDR  (paddr),
    .PWDATA (pwdata),
    .PREADY (pready),
    .PRDATA (prdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction descriptors per requester and the model's view of the master.
  logic        t_we[2];
  logic [31:0] t_addr[2], t_wdata[2], t_prdata[2];
  int          t_wait[2];
  bit          drop_mid;
  int          last_served;
  logic [31:0] model_rdata;
  logic [1:0]  pend;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic serve_one(input int exp_lat);
    int winner, cyc, k;
    bit fin, exp_err;
    logic [1:0] expg;
    if (pend == 2'b11) winner = (last_served == 0) ? 1 : 0;
    else winner = pend[0] ? 0 : 1;
    expg = 2'(1 << winner);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;
    end while (!psel && cyc < 8);
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    if (!psel) begin
      pend = 2'b00;
      req  = 2'b00;
      return;
    end
    check_eq("setup_gnt", 64'(gnt), 64'(expg));
    check_eq("setup_penable", 64'(penable), 64'd0);
    check_eq("setup_pwrite", 64'(pwrite), 64'(t_we[winner]));
    check_eq("setup_paddr", 64'(paddr), 64'(t_addr[winner]));
    if (t_we[winner]) check_eq("setup_pwdata", 64'(pwdata), 64'(t_wdata[winner]));
    if (drop_mid) req[winner] = 1'b0;
    k = 0;
    fin = 0;
    exp_err = 0;
    while (!fin) begin
      @(negedge clk);
      check_eq("access_psel_penable", 64'({psel, penable}), 64'd3);
      check_eq("access_paddr", 64'(paddr), 64'(t_addr[winner]));
      check_eq("access_gnt", 64'(gnt), 64'(expg));
      if (t_we[winner]) check_eq("access_pwdata", 64'(pwdata), 64'(t_wdata[winner]));
      pready = (k == t_wait[winner]);
      prdata = (k == t_wait[winner]) ? t_prdata[winner] : $urandom;
      if (k == t_wait[winner]) begin
        fin = 1;
        if (!t_we[winner]) model_rdata = t_prdata[winner];
      end else if (k == int'(TIMEOUT) - 1) begin
        fin = 1;
        exp_err = 1;
      end
      k++;
    end
    @(negedge clk);
    pready = 1'b0;
    check_eq("done", 64'(done), 64'(expg));
    check_eq("err", 64'(err), exp_err ? 64'(expg) : 64'd0);
    check_eq("rdata", 64'(rdata), 64'(model_rdata));
    check_eq("idle_bus", 64'({psel, penable, gnt}), 64'd0);
    req[winner]  = 1'b0;
    pend[winner] = 1'b0;
    last_served  = winner;
  endtask

  task automatic run_round(input logic [1:0] mask);
    we    = {t_we[1], t_we[0]};
    addr  = {t_addr[1], t_addr[0]};
    wdata = {t_wdata[1], t_wdata[0]};
    req   = mask;
    pend  = mask;
    serve_one(1);
    if (pend != 2'b00) serve_one(2);
    @(negedge clk);
    pready = 1'($urandom_range(0, 1));
    prdata = $urandom;
    check_eq("done_single_pulse", 64'({done, err}), 64'd0);
    check_eq("rdata_hold", 64'(rdata), 64'(model_rdata));
  endtask

  task automatic set_xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int wt);
    t_we[i]     = w;
    t_addr[i]   = a;
    t_wdata[i]  = d;
    t_prdata[i] = rd;
    t_wait[i]   = wt;
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 7));
    case (r)
      4:       return int'(TIMEOUT) - 1;
      5:       return int'(TIMEOUT);
      6:       return int'(TIMEOUT) + int'($urandom_range(1, 3));
      7:       return int'($urandom_range(0, TIMEOUT));
      default: return int'($urandom_range(0, 4));
    endcase
  endfunction

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; pready = 1'b0; prdata = '0;
    drop_mid = 0; last_served = 1; model_rdata = '0; pend = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'({gnt, done, err, psel, penable, pwrite}), 64'd0);
    check_eq("reset_rdata", 64'(rdata), 64'd0);
    check_eq("reset_paddr_pwdata", {paddr, pwdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed: single write, read with waits, contention, timeout, ready on the last cycle.
    set_xfer(0, 1'b1, 32'hffff_0f0f, 32'd201, 32'd0, 0);
    run_round(2'b01);
    set_xfer(1, 1'b0, 32'hf0f0_ffff, 32'd0, 32'd201, 3);
    run_round(2'b10);
    for (int r = 0; r < 2; r++) begin
      set_xfer(0, 1'b1, $urandom, $urandom, $urandom, 1);
      set_xfer(1, 1'b0, $urandom, $urandom, $urandom, 0);
      run_round(2'b11);
    end
    set_xfer(0, 1'b0, 32'h1234_5678, 32'd0, 32'hdead_beef, int'(TIMEOUT) + 5);
    run_round(2'b01);
    set_xfer(1, 1'b0, 32'h0000_0040, 32'd0, 32'h0bad_cafe, int'(TIMEOUT) - 1);
    run_round(2'b10);

    // Reset in the middle of ACCESS: bus drops at once, no completion pulse.
    set_xfer(1, 1'b0, 32'h0000_0080, 32'd0, 32'd7, 100);
    we = {t_we[1], t_we[0]};
    addr = {t_addr[1], t_addr[0]};
    req = 2'b10;
    pready = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_psel", 64'(psel), 64'd1);
    @(negedge clk);
    check_eq("rst_pre_penable", 64'(penable), 64'd1);
    #2 rst = 1'b1;
    #1 check_eq("rst_async_drop", 64'({psel, penable, gnt}), 64'd0);
    req = 2'b00;
    @(negedge clk);
    check_eq("rst_no_done", 64'({done, err}), 64'd0);
    rst = 1'b0;
    last_served = 1;
    model_rdata = '0;
    @(negedge clk);
    set_xfer(0, 1'b0, $urandom, $urandom, $urandom, 0);
    set_xfer(1, 1'b1, $urandom, $urandom, $urandom, 2);
    run_round(2'b11);

    // Randomized rounds.
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < 2; i++)
        set_xfer(i, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, pick_wait());
      drop_mid = ($urandom_range(0, 3) == 0);
      run_round(2'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
